// File: rtl/halfband_interp_pkg.sv
// halfband_interp_pkg: shared halfband widths, coefficient table and saturation helper
package halfband_interp_pkg;
  localparam int WIDTH = 18;
  localparam int CWIDTH = 18;
  localparam int ACC_WIDTH = 40;
  localparam int SHIFT = 15;
  localparam int TAPS = 16;
  localparam logic signed [CWIDTH-1:0] HB31_COEFFS [8] = '{
    -18'sd1390, 18'sd1604, -18'sd1896, 18'sd2317,
    -18'sd2979, 18'sd4172, -18'sd6953, 18'sd20860
  };
  function automatic logic signed [WIDTH-1:0] sat_width(input logic signed [ACC_WIDTH-1:0] v);
    return (&v[ACC_WIDTH-1:WIDTH-1] || ~|v[ACC_WIDTH-1:WIDTH-1]) ? v[WIDTH-1:0]
         : {v[ACC_WIDTH-1], {(WIDTH-1){~v[ACC_WIDTH-1]}}};
  endfunction
endpackage

// File: rtl/hb_mac_seq.sv
// hb_mac_seq: 8-step symmetric pre-add/multiply/accumulate sequencer with saturating result
module hb_mac_seq
  import halfband_interp_pkg::*;
(
  input  logic                    clock,
  input  logic                    i_abort,
  input  logic                    i_start,
  input  logic signed [WIDTH-1:0] i_x [TAPS],
  output logic                    o_busy,
  output logic                    o_done,
  output logic signed [WIDTH-1:0] o_result
);
  localparam int PW = WIDTH + CWIDTH + 1;
  logic [3:0] r_cnt;
  logic r_busy;
  logic signed [WIDTH:0] r_pre;
  logic signed [PW-1:0] r_prod;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic [3:0] w_a, w_b;
  logic [2:0] w_km;
  // r_cnt is the cycle number since start: pre-add in 1..8, multiply in 2..9, accumulate in 3..10
  always_comb begin
    w_a = r_cnt - 4'd1;
    w_b = 4'd15 - w_a;
    w_km = 3'(r_cnt - 4'd2);
  end
  always_ff @(posedge clock) begin
    if (i_abort) begin
      r_busy <= 1'b0;
      r_cnt <= '0;
      r_pre <= '0;
      r_prod <= '0;
      r_acc <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt <= 4'd1;
      r_acc <= '0;
    end else if (r_busy) begin
      r_cnt <= r_cnt + 4'd1;
      r_busy <= r_cnt != 4'd11;
      if (r_cnt <= 4'd8) r_pre <= {i_x[w_a][WIDTH-1], i_x[w_a]} + {i_x[w_b][WIDTH-1], i_x[w_b]};
      if (r_cnt >= 4'd2 && r_cnt <= 4'd9) r_prod <= PW'(r_pre) * PW'(HB31_COEFFS[w_km]);
      if (r_cnt >= 4'd3 && r_cnt <= 4'd10) r_acc <= r_acc + ACC_WIDTH'(r_prod);
    end
  end
  assign o_busy = r_busy;
  assign o_done = r_busy && r_cnt == 4'd11;
  assign o_result = sat_width(r_acc >>> SHIFT);
endmodule

// File: rtl/halfband_interp.sv
// halfband_interp: 31-tap halfband 2x polyphase interpolator (delayed centre tap + time-multiplexed odd FIR)
module halfband_interp
  import halfband_interp_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    strobe_in,
  input  logic signed [WIDTH-1:0] data_in,
  input  logic                    strobe_out,
  output logic signed [WIDTH-1:0] data_out,
  output logic                    valid_out,
  output logic                    busy,
  output logic                    overrun
);
  logic w_clear, w_done;
  logic signed [WIDTH-1:0] w_result;
  logic signed [WIDTH-1:0] r_x [TAPS];
  logic signed [WIDTH-1:0] r_ctr_pend, r_odd_pend, r_odd_hold, r_data_out;
  logic r_valid, r_overrun;
  assign w_clear = reset || !enable;
  hb_mac_seq u_mac (
    .clock    (clock),
    .i_abort  (w_clear),
    .i_start  (strobe_in),
    .i_x      (r_x),
    .o_busy   (busy),
    .o_done   (w_done),
    .o_result (w_result)
  );
  // A strobe_in landing on the done cycle restarts the MAC, so that result is dropped
  always_ff @(posedge clock) begin
    if (w_clear) begin
      r_x <= '{default: '0};
      r_ctr_pend <= '0;
      r_odd_pend <= '0;
      r_odd_hold <= '0;
      r_data_out <= '0;
      r_valid <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid <= strobe_out;
      if (strobe_out) r_data_out <= strobe_in ? r_ctr_pend : r_odd_hold;
      if (strobe_in) begin
        r_x[0] <= data_in;
        for (int i = 1; i < TAPS; i++) r_x[i] <= r_x[i-1];
        r_ctr_pend <= r_x[6];
        r_odd_hold <= r_odd_pend;
        r_overrun <= r_overrun || busy;
      end else if (w_done) r_odd_pend <= w_result;
    end
  end
  assign data_out = r_data_out;
  assign valid_out = r_valid;
  assign overrun = r_overrun;
endmodule
